// File: rtl/frame_writer.sv
// rtl/frame_writer.sv - packs a pixel stream into memory words and writes a frame through a small word FIFO
// Optional row padding to word boundaries: FRAME_WRITER_ROW_PAD_EN
module frame_writer #(
   parameter int               PIXEL      = 8,
   parameter int               PACK       = 4,
   parameter int               EADDR      = 32,
   parameter int               OUT_SIZE   = 510,
   parameter logic [EADDR-1:0] BASE_ADDR  = '0,
   parameter int               FIFO_DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   pix_valid,
   input  logic [PIXEL-1:0]       pix_data,
   output logic                   wr_en,
   output logic [EADDR-1:0]       wr_addr,
   output logic [PIXEL*PACK-1:0]  wr_data,
   input  logic                   wr_ready,
   output logic                   busy,
   output logic                   frame_done,
   output logic                   overflow
);

   localparam int WORD  = PIXEL * PACK;
   localparam int TOTAL = OUT_SIZE * OUT_SIZE;
   localparam int PCW   = $clog2(TOTAL + 1);
   localparam int LW    = (PACK > 1) ? $clog2(PACK) : 1;
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int FCW   = AW + 1;
`ifdef FRAME_WRITER_ROW_PAD_EN
   localparam int CW    = $clog2(OUT_SIZE + 1);
`endif

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

   state_t            state, state_nx;
   logic [PCW-1:0]    pix_cnt;
   logic [LW-1:0]     lane_cnt;
   logic [WORD-1:0]   pack_reg;
   logic [EADDR-1:0]  push_addr;
   logic              ovf_reg;
`ifdef FRAME_WRITER_ROW_PAD_EN
   logic [CW-1:0]     col_cnt;
`endif

   logic [WORD-1:0]   mem_data [FIFO_DEPTH];
   logic [EADDR-1:0]  mem_addr [FIFO_DEPTH];
   logic [AW-1:0]     rd_ptr, wr_ptr;
   logic [FCW-1:0]    fifo_cnt, cnt_nx;

   logic              accept, last_pix, final_lane, row_end;
   logic              push, pop, full, push_ok, drop;
   logic [WORD-1:0]   word_nx;

   // Datapath: the incoming pixel merged into the pending word
   always_comb begin
      accept     = (state == S_RUN) && pix_valid;
      last_pix   = (pix_cnt == PCW'(TOTAL - 1));
      final_lane = (lane_cnt == LW'(PACK - 1));
`ifdef FRAME_WRITER_ROW_PAD_EN
      row_end    = (col_cnt == CW'(OUT_SIZE - 1));
`else
      row_end    = 1'b0;
`endif
      word_nx = pack_reg;
      word_nx[int'(lane_cnt)*PIXEL +: PIXEL] = pix_data;
      push    = accept && (final_lane || last_pix || row_end);
      pop     = wr_en && wr_ready;
      full    = (fifo_cnt == FCW'(FIFO_DEPTH));
      push_ok = push && (!full || pop);
      drop    = push && full && !pop;
      cnt_nx  = fifo_cnt;
      if (push_ok && !pop) begin
         cnt_nx = fifo_cnt + FCW'(1);
      end else if (!push_ok && pop) begin
         cnt_nx = fifo_cnt - FCW'(1);
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (start) state_nx = S_RUN;
         S_RUN:   if (accept && last_pix) state_nx = S_FLUSH;
         S_FLUSH: if (cnt_nx == '0) state_nx = S_DONE;
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         pix_cnt   <= '0;
         lane_cnt  <= '0;
         pack_reg  <= '0;
         push_addr <= BASE_ADDR;
         ovf_reg   <= 1'b0;
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         fifo_cnt  <= '0;
`ifdef FRAME_WRITER_ROW_PAD_EN
         col_cnt   <= '0;
`endif
      end else begin
         state <= state_nx;
         if (state == S_IDLE && start) begin
            pix_cnt   <= '0;
            lane_cnt  <= '0;
            pack_reg  <= '0;
            push_addr <= BASE_ADDR;
            ovf_reg   <= 1'b0;
`ifdef FRAME_WRITER_ROW_PAD_EN
            col_cnt   <= '0;
`endif
         end else if (accept) begin
            pix_cnt <= pix_cnt + PCW'(1);
            // A dropped word still consumes its address
            if (push) begin
               lane_cnt  <= '0;
               pack_reg  <= '0;
               push_addr <= push_addr + EADDR'(1);
            end else begin
               lane_cnt <= lane_cnt + LW'(1);
               pack_reg <= word_nx;
            end
`ifdef FRAME_WRITER_ROW_PAD_EN
            col_cnt <= row_end ? '0 : col_cnt + CW'(1);
`endif
         end
         if (drop) begin
            ovf_reg <= 1'b1;
         end
         if (push_ok) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         fifo_cnt <= cnt_nx;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_data[wr_ptr] <= word_nx;
         mem_addr[wr_ptr] <= push_addr;
      end
   end

   // Head is gated so an empty or freshly reset FIFO presents zeros
   assign wr_en      = (fifo_cnt != '0);
   assign wr_addr    = wr_en ? mem_addr[rd_ptr] : '0;
   assign wr_data    = wr_en ? mem_data[rd_ptr] : '0;
   assign busy       = (state == S_RUN) || (state == S_FLUSH);
   assign frame_done = (state == S_DONE);
   assign overflow   = ovf_reg;

endmodule

// File: tb/tb_frame_writer.sv
// tb/tb_frame_writer.sv - scoreboard bench for frame_writer on a 10x10 frame
module tb_frame_writer;

   localparam int OUT   = 10;
   localparam int PACK  = 4;
   localparam int DEPTH = 8;
   localparam int TOTAL = OUT * OUT;
   localparam logic [31:0] BASE = 32'h100;
`ifdef FRAME_WRITER_ROW_PAD_EN
   localparam int WORDS = OUT * ((OUT + PACK - 1) / PACK);
   localparam int C_SKIP = 12;
`else
   localparam int WORDS = (TOTAL + PACK - 1) / PACK;
   localparam int C_SKIP = 10;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, pix_valid, wr_ready;
   logic [7:0]  pix_data;
   logic        wr_en, busy, frame_done, overflow;
   logic [31:0] wr_addr, wr_data;

   frame_writer #(
      .PIXEL(8), .PACK(PACK), .EADDR(32), .OUT_SIZE(OUT),
      .BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .pix_valid(pix_valid),
      .pix_data(pix_data), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_ready(wr_ready), .busy(busy), .frame_done(frame_done), .overflow(overflow)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } ent_t;

   ent_t        exp_q[$];
   ent_t        log_q[$];
   int          checks = 0;
   int          errors = 0;
   int          m_state = 0;
   int          m_pix, m_col, m_lane;
   logic [31:0] m_pack, m_addr;
   logic        m_ovf = 1'b0;
   int          frame_pops = 0;
   int          done_cnt = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic will_push();
      logic p;
      p = (m_lane == PACK - 1) || (m_pix == TOTAL - 1);
`ifdef FRAME_WRITER_ROW_PAD_EN
      p = p || (m_col == OUT - 1);
`endif
      return p;
   endfunction

   // One clock: drive at the falling edge, check, advance the model, step past the next rising edge
   task automatic tick(input logic st, input logic pv, input logic [7:0] pd, input logic rdy);
      logic full, mpop, psh;
      ent_t e;
      start = st; pix_valid = pv; pix_data = pd; wr_ready = rdy;
      #1;
      check("busy", busy, (m_state == 1 || m_state == 2));
      check("frame_done", frame_done, m_state == 3);
      check("overflow", overflow, m_ovf);
      check("wr_en", wr_en, exp_q.size() != 0);
      if (frame_done) done_cnt++;
      full = (exp_q.size() == DEPTH);
      mpop = (exp_q.size() != 0) && rdy;
      if (mpop) begin
         e = exp_q.pop_front();
         check("wr_addr", wr_addr, e.addr);
         check("wr_data", wr_data, e.data);
         log_q.push_back({wr_addr, wr_data});
         frame_pops++;
      end
      case (m_state)
         0: if (st) begin
               m_state = 1; m_pix = 0; m_col = 0; m_lane = 0;
               m_pack = '0; m_addr = BASE; m_ovf = 1'b0; frame_pops = 0;
            end
         1: if (pv) begin
               psh = will_push();
               m_pack[m_lane*8 +: 8] = pd;
               if (psh) begin
                  if (full && !mpop) m_ovf = 1'b1;
                  else exp_q.push_back({m_addr, m_pack});
                  m_addr = m_addr + 1;
                  m_lane = 0;
                  m_pack = '0;
               end else begin
                  m_lane++;
               end
               m_col = (m_col == OUT - 1) ? 0 : m_col + 1;
               m_pix++;
               if (m_pix == TOTAL) m_state = 2;
            end
         2: if (exp_q.size() == 0) m_state = 3;
         default: m_state = 0;
      endcase
      @(posedge clk);
      @(negedge clk);
   endtask

   // rmode: 0 ready, 1 stalled, 2 random gaps/ready, 3 ready only for a push into a full FIFO
   task automatic feed(input int n, input int rmode, input int vmode, input int st_at);
      int got = 0;
      int guard = 0;
      while (got < n && guard < 2000) begin
         logic pv, rdy, st;
         logic [7:0] v;
         pv = (rmode == 2) ? ($urandom_range(3) != 0) : 1'b1;
         v = (vmode == 0) ? 8'(m_pix + 1) : 8'((m_pix / OUT) + (m_pix % OUT));
         case (rmode)
            0: rdy = 1'b1;
            1: rdy = 1'b0;
            2: rdy = ($urandom_range(3) != 0);
            default: rdy = (exp_q.size() == DEPTH) && will_push();
         endcase
         st = (got == st_at);
         tick(st, pv, v, rdy);
         if (pv) got++;
         guard++;
      end
      check("feed_bound", got, n);
   endtask

   task automatic finish_frame();
      for (int i = 0; i < 100 && m_state != 0; i++) tick(1'b0, 1'b0, 8'h00, 1'b1);
      check("frame_bound", m_state == 0, 1);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; pix_valid = 1'b0; pix_data = 8'h00; wr_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_wr_en", wr_en, 0);
      check("rst_wr_addr", wr_addr, 0);
      check("rst_wr_data", wr_data, 0);
      check("rst_busy", busy, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_overflow", overflow, 0);
      rst_n = 1'b1;

      // Incrementing pixels, memory always ready
      log_q.delete(); done_cnt = 0;
      tick(1'b1, 1'b0, 8'h00, 1'b1);
      feed(TOTAL, 0, 0, -1);
      finish_frame();
      check("a_word0_addr", log_q[0].addr, 32'h100);
      check("a_word0_data", log_q[0].data, 32'h04030201);
      check("a_word1_addr", log_q[1].addr, 32'h101);
      check("a_word1_data", log_q[1].data, 32'h08070605);
      check("a_words", frame_pops, WORDS);
      check("a_done_pulses", done_cnt, 1);
      check("a_overflow", overflow, 0);

      // (row+col) pixels, random gaps and backpressure, stray start in RUN and pixels in IDLE
      done_cnt = 0;
      tick(1'b1, 1'b0, 8'h00, 1'b1);
      feed(TOTAL, 2, 1, 20);
      finish_frame();
      repeat (6) tick(1'b0, 1'b1, 8'hAA, 1'b1);
      check("b_words", frame_pops, WORDS);
      check("b_done_pulses", done_cnt, 1);

      // Memory stalled for 40 pixels: FIFO fills and later words are dropped
      log_q.delete();
      tick(1'b1, 1'b0, 8'h00, 1'b0);
      feed(40, 1, 0, -1);
      feed(TOTAL - 40, 0, 0, -1);
      finish_frame();
      check("c_overflow", overflow, 1);
      check("c_addr0", log_q[0].addr, BASE);
      check("c_addr7", log_q[7].addr, BASE + 32'd7);
      check("c_addr8", log_q[8].addr, BASE + 32'(C_SKIP));

      // Full FIFO receiving a push on the same edge as a pop
      tick(1'b1, 1'b0, 8'h00, 1'b0);
      feed(60, 3, 1, -1);
      feed(TOTAL - 60, 0, 1, -1);
      finish_frame();
      check("d_overflow", overflow, 0);
      check("d_words", frame_pops, WORDS);

      // Reset mid-row with words queued, then a clean frame
      tick(1'b1, 1'b0, 8'h00, 1'b0);
      feed(13, 1, 0, -1);
      check("e_queued", wr_en, 1);
      rst_n = 1'b0;
      #1;
      check("e_rst_wr_en", wr_en, 0);
      check("e_rst_wr_addr", wr_addr, 0);
      check("e_rst_wr_data", wr_data, 0);
      check("e_rst_busy", busy, 0);
      check("e_rst_overflow", overflow, 0);
      m_state = 0; m_ovf = 1'b0; exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      log_q.delete(); done_cnt = 0;
      tick(1'b1, 1'b0, 8'h00, 1'b1);
      feed(TOTAL, 0, 1, -1);
      finish_frame();
      check("e_first_addr", log_q[0].addr, BASE);
      check("e_first_data", log_q[0].data, 32'h03020100);
      check("e_words", frame_pops, WORDS);
      check("e_done_pulses", done_cnt, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
